// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_if
// Brief    : Bundles the pushbutton conditioner's strobe, raw inputs and outputs.
// Revision : 1.0  initial release
// ============================================================================
interface button_conditioner_if #(
  parameter int NUM_BTN = 5
);
  logic               sample_en;
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic               any_pressed;
  logic               collision;

  modport master (
    output sample_en, btn_in,
    input  btn_level, btn_pulse, any_pressed, collision
  );

  modport slave (
    input  sample_en, btn_in,
    output btn_level, btn_pulse, any_pressed, collision
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronise, debounce and arbitrate five pushbuttons into a
//            one-hot single-cycle press vector. Define BUTTON_AUTO_REPEAT_EN
//            to add auto-repeat pulses for held REPEAT_MASK buttons.
// Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
  parameter int                 NUM_BTN        = 5,
  parameter int                 DEBOUNCE_TICKS = 4,
  parameter int                 REPEAT_DELAY   = 100,
  parameter int                 REPEAT_PERIOD  = 20,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK    = 5'b11000
) (
  input  logic               clk,
  input  logic               reset,
  button_conditioner_if.slave bus
);
  localparam logic [7:0]         DB_LAST = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [NUM_BTN-1:0] ONE     = NUM_BTN'(1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] prev_q;
  logic [7:0]         db_cnt_q [NUM_BTN];
  logic [7:0]         db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rise, press, rep_req;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               any_q, any_d;
  logic               coll_q, coll_d;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (bus.sample_en) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = ~level_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // x & -x isolates the lowest set bit, so the lowest index wins arbitration
  assign rise  = level_q & ~prev_q;
  assign press = rise & (~rise + ONE);

  always_comb begin
    pulse_d = (press != '0) ? press : rep_req;
    coll_d  = ((rise & (rise - ONE)) != '0);
    any_d   = |level_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      coll_q  <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      pulse_q <= pulse_d;
      any_q   <= any_d;
      coll_q  <= coll_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_WAIT     = 2'd1;
  localparam logic [1:0]  ST_REPEAT   = 2'd2;
  localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

  logic [1:0]         state_q, state_d;
  logic [15:0]        rep_cnt_q, rep_cnt_d;
  logic [NUM_BTN-1:0] rep_req_q, rep_req_d;
  logic               held_ok;
  logic               level_chg;

  assign held_ok   = (level_d != '0) && ((level_d & (level_d - ONE)) == '0) &&
                     ((level_d & REPEAT_MASK) != '0);
  assign level_chg = (level_d != level_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      rep_req_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      rep_req_q <= rep_req_d;
    end
  end

  // Any level change re-evaluates from scratch, so a new one-hot hold restarts the delay
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    if (bus.sample_en) begin
      if (level_chg || state_q == ST_IDLE) begin
        state_d   = held_ok ? ST_WAIT : ST_IDLE;
        rep_cnt_d = '0;
      end else begin
        case (state_q)
          ST_WAIT: begin
            if (rep_cnt_q == DELAY_LAST) begin
              state_d   = ST_REPEAT;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 16'd1;
            end
          end
          ST_REPEAT: begin
            rep_cnt_d = (rep_cnt_q == PERIOD_LAST) ? 16'd0 : rep_cnt_q + 16'd1;
          end
          default: begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    rep_req_d = '0;
    if (bus.sample_en && !level_chg) begin
      if ((state_q == ST_WAIT   && rep_cnt_q == DELAY_LAST) ||
          (state_q == ST_REPEAT && rep_cnt_q == PERIOD_LAST)) begin
        rep_req_d = level_q;
      end
    end
  end

  assign rep_req = rep_req_q;
`else
  assign rep_req = '0;
`endif

  assign bus.btn_level   = level_q;
  assign bus.btn_pulse   = pulse_q;
  assign bus.any_pressed = any_q;
  assign bus.collision   = coll_q;

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage for the clock/alarm mode FSM.
- Takes the five raw board pushbuttons (C, L, R, U, D) and synchronises and debounces them.
- Outputs a one-hot, single-cycle press vector. The FSM compares this vector directly against one-hot codes.
- Optionally generates auto-repeat pulses for held buttons so time/alarm digits can be scrolled while adjusting.

Parameters:
- NUM_BTN, 5: number of buttons. Bit order: 0=C, 1=L, 2=R, 3=D, 4=U, so the vector reads {U,D,R,L,C}.
- DEBOUNCE_TICKS, 4: consecutive sample ticks a new level must persist before it is accepted. Range 1..255.
- REPEAT_DELAY, 100: sample ticks from accepted press to first repeat pulse. 100 ticks = 0.5 s at 200 Hz.
- REPEAT_PERIOD, 20: sample ticks between subsequent repeat pulses.
- REPEAT_MASK, 5'b11000: buttons eligible for auto-repeat (U, D).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- sample_en, input, 1: single-cycle debounce sample strobe (200 Hz divider tick).
- btn_in, input, NUM_BTN: raw asynchronous button levels, active-high.
- btn_level, output, NUM_BTN: debounced stable level per button.
- btn_pulse, output, NUM_BTN: one-hot press/repeat pulse, one clk wide.
- any_pressed, output, 1: OR of btn_level.
- collision, output, 1: one-clk pulse when simultaneous presses were arbitrated.

Behaviour:
- Reset: all sync flops, btn_level, debounce counters, repeat counter, btn_pulse, any_pressed and collision are cleared to 0.
- Reset is sampled only on posedge clk. Asserting it mid-debounce or mid-repeat discards all history. After reset deasserts, a button that is already held must re-qualify through the full debounce.
- Synchroniser: two flops per bit, clocked every clk, independent of sample_en.
- Debounce, per bit, evaluated only in cycles where sample_en=1:
  - sync == btn_level: counter clears to 0.
  - sync != btn_level and counter == DEBOUNCE_TICKS-1: btn_level toggles, counter clears.
  - Otherwise the counter increments.
  - The counter is 8 bits wide and never wraps, given the parameter range.
- Press detect: rise[i] = btn_level[i] set this cycle (registered old level 0, new level 1). Releases generate no pulse.
- Arbitration:
  - If more than one rise bit is set in the same cycle, only the lowest index is forwarded.
  - collision pulses high in that same output cycle.
  - Pressing a second button while the first is held is a normal single rise and produces a normal pulse.
- Output timing: btn_pulse is registered, high exactly the clk cycle after the rise cycle. It is zero in every other cycle.
- Latency, raw edge to btn_pulse: 2 clk (sync) + DEBOUNCE_TICKS sample ticks + 1 clk.
- One-hot guarantee: btn_pulse never has more than one bit set, including when a press and a repeat coincide. Press wins, and the repeat counter restarts from 0.
- any_pressed: registered OR of btn_level; same cycle timing as btn_level.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: a repeat FSM is compiled in, evaluated on sample_en only.
  - IDLE → WAIT when btn_level is exactly one-hot and that bit is in REPEAT_MASK. The counter starts at 0 on the rise.
  - WAIT: when counter reaches REPEAT_DELAY-1, emit a pulse for that bit → REPEAT, counter 0.
  - REPEAT: emit a pulse every REPEAT_PERIOD ticks.
  - Any change of btn_level (release, or an extra button) → IDLE immediately.
  - Repeat pulses obey the same registered timing and one-hot rule as press pulses.
- Undefined: no repeat logic, and a held button yields exactly one pulse.

Test Plan:
- Clean press of U (btn_in=5'b10000) with DEBOUNCE_TICKS=4 and sample_en every 4 clk → exactly one btn_pulse=5'b10000, 2+16+1 (±4) clk after the edge. btn_level=5'b10000 and any_pressed=1 while held.
- Bounce: R toggles 0/1 every 2 sample ticks for 20 ticks, then stays 1 → no pulse during bounce, then one btn_pulse=5'b00100.
- Simultaneous: C and L rise in the same clk → btn_pulse=5'b00001 with collision=1 in the same cycle. No pulse for L until it is released and re-pressed.
- Reset mid-debounce: after 2 of 4 ticks of a D press, assert reset for 1 clk → all outputs 0. D then needs a full 4 ticks before btn_pulse=5'b01000.
- Auto-repeat (BUTTON_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3), D held for 20 ticks after acceptance → pulses at ticks 0, 10, 13, 16, 19.
  - Holding C (not in REPEAT_MASK) yields one pulse only.
  - Without the macro, D also yields one pulse only.
- Hold D then press U: U gets a single pulse, D repeat stops, and the FSM stays in IDLE until one-hot again.
